eprom_programmer: RTL and testbench



---
 rtl/eprom_programmer_if.sv | 27 ++
 rtl/eprom_programmer.sv | 139 +++++++++++++
 tb/tb_eprom_programmer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eprom_programmer_if.sv
// Word-stream and EPROM bus bundle for eprom_programmer.
// slave: programmer side; master: source + EPROM side.
interface eprom_programmer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_erase;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_addr, mem_we,
    output mem_wdata, mem_erase
  );

  modport master (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_addr, mem_we,
    input  mem_wdata, mem_erase
  );
endinterface

// File: rtl/eprom_programmer.sv
// EPROM programmer: optional erase+check, then write/verify DEPTH words.
// Ports: clk, rst_n, start, do_erase, bus (slave), busy, done, error, err_addr, words_written.
module eprom_programmer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              do_erase,
  eprom_programmer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_ECHK,
    S_PROG,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [ADDR_W:0]   words_q, words_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    error_d = error_q;
    eaddr_d = eaddr_q;
    words_d = words_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          eaddr_d = '0;
          words_d = '0;
          cnt_d   = '0;
          state_d = do_erase ? S_ERASE : S_PROG;
        end
      end
      S_ERASE: begin
        cnt_d   = '0;
        state_d = S_ECHK;
      end
      S_ECHK: begin
        if (bus.mem_rdata != '0) begin
          eaddr_d = cnt_q;
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_PROG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PROG: begin
        // The EPROM captures the write on this same edge.
        if (bus.in_valid) begin
          exp_d   = bus.in_data;
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (bus.mem_rdata == exp_q) begin
          words_d = words_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_PROG;
          end
        end else begin
          eaddr_d = cnt_q;
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      error_q <= 1'b0;
      eaddr_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      error_q <= error_d;
      eaddr_q <= eaddr_d;
      words_q <= words_d;
    end
  end

  logic addr_en;

  always_comb begin
    addr_en = (state_q == S_ECHK) ||
              (state_q == S_PROG) ||
              (state_q == S_VERIFY);
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;
  assign err_addr      = eaddr_q;
  assign words_written = words_q;

  assign bus.in_ready  = (state_q == S_PROG);
  assign bus.mem_we    = bus.in_ready && bus.in_valid;
  // Gated so the bus is quiet outside PROG and under reset.
  assign bus.mem_wdata = bus.in_ready ? bus.in_data : '0;
  assign bus.mem_erase = (state_q == S_ERASE);
  assign bus.mem_addr  = addr_en ? cnt_q : '0;

endmodule

// File: tb/tb_eprom_programmer.sv
// Testbench for eprom_programmer with EPROM model and outcome model.
// Table scenarios, hand-written reset sequence, randomized sessions.
module tb_eprom_programmer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       do_erase = 1'b0;
  logic       busy, done, error;
  logic [3:0] err_addr;
  logic [4:0] words_written;

  eprom_programmer_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  eprom_programmer #(
    .ADDR_W(4), .DATA_W(16), .DEPTH(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .do_erase      (do_erase),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_addr      (err_addr),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [15:0] mem [16];
  logic [15:0] pre_arr [16];
  logic [15:0] words_tb [16];
  bit          stuck5 = 0;
  bit          bad9 = 0;
  bit          preload_req = 0;

  assign bus.mem_rdata = mem[bus.mem_addr] |
    {15'd0, stuck5 && (bus.mem_addr == 4'd5)};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= pre_arr[i];
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_erase)
        for (int i = 0; i < 16; i++)
          mem[i] <= (bad9 && i == 9) ? 16'h0001 : 16'h0000;
    end
  end

  int         nwr, nerase, nready, nviol;
  logic [3:0] exp_wa;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        nwr++;
        if (!(bus.in_valid && bus.in_ready) ||
            bus.mem_addr != exp_wa ||
            bus.mem_wdata != bus.in_data)
          nviol++;
        exp_wa++;
      end
      if (bus.mem_erase) nerase++;
      if (bus.in_ready) nready++;
    end
  end

  function automatic logic [63:0] outs_vec();
    return {busy, done, error, err_addr, words_written,
            bus.in_ready, bus.mem_we, bus.mem_erase,
            bus.mem_addr, bus.mem_wdata};
  endfunction

  // Outcome model: straight from the session rules, word by word.
  bit          m_err;
  int          m_ea, m_w, m_nwr;
  logic [15:0] m_fin [16];

  function automatic void model(input bit e);
    logic [15:0] rb;
    m_err = 0; m_ea = 0; m_w = 0; m_nwr = 0;
    for (int i = 0; i < 16; i++) m_fin[i] = pre_arr[i];
    if (e) begin
      for (int i = 0; i < 16; i++)
        m_fin[i] = (bad9 && i == 9) ? 16'h1 : 16'h0;
      for (int i = 0; i < 16; i++) begin
        rb = m_fin[i] | ((stuck5 && i == 5) ? 16'h1 : 16'h0);
        if (!m_err && rb != 0) begin m_err = 1; m_ea = i; end
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (!m_err) begin
        m_fin[i] = words_tb[i];
        m_nwr++;
        rb = words_tb[i] | ((stuck5 && i == 5) ? 16'h1 : 16'h0);
        if (rb != words_tb[i]) begin m_err = 1; m_ea = i; end
        else m_w++;
      end
    end
  endfunction

  task automatic run_session(input bit e, input int gapmax,
                             input int rst_at,
                             output bit r_err, output bit r_done,
                             output int r_ea, output int r_w,
                             output int r_lat);
    int idx = 0;
    int c0 = -1;
    bit hs = 0;
    bit fin = 0;
    r_done = 0; r_lat = -1;
    nwr = 0; nerase = 0; nready = 0; nviol = 0; exp_wa = 0;
    @(posedge clk); #1;
    start = 1; do_erase = e; bus.in_valid = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (hs) begin
        if (c0 < 0) c0 = cyc - 1;
        idx++;
      end
      // A start pulse mid-session must be ignored.
      start = (cyc == 3);
      do_erase = (cyc == 3);
      bus.in_valid = (idx < 16) &&
        (gapmax == 0 || $urandom_range(0, gapmax) == 0);
      bus.in_data = words_tb[idx % 16];
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (rst_at >= 0 && idx == rst_at && bus.in_ready) begin
        #2 rst_n = 0;
        #1 chk("reset_mid_prog_outs", outs_vec(), 64'd0);
        fin = 1;
      end else if (done) begin
        r_done = 1; r_lat = cyc - c0; fin = 1;
      end else if (error) begin
        fin = 1;
      end
    end
    if (!fin) chk("session_timeout", 64'd1, 64'd0);
    start = 0; do_erase = 0; bus.in_valid = 0;
    r_err = error; r_ea = int'(err_addr); r_w = int'(words_written);
  endtask

  task automatic setup(input bit s5, input bit b9, input int dmode);
    stuck5 = s5; bad9 = b9;
    for (int i = 0; i < 16; i++) begin
      pre_arr[i] = 16'(i + 1);
      case (dmode)
        0: words_tb[i] = 16'hA000 + 16'(i);
        1: words_tb[i] = 16'h0000;
        default: words_tb[i] = 16'($urandom);
      endcase
    end
    @(posedge clk); #1 preload_req = 1;
    @(posedge clk); #1 preload_req = 0;
  endtask

  task automatic do_scen(input bit e, input bit s5, input bit b9,
                         input int gapmax, input int dmode,
                         input bit tab, input bit t_err,
                         input int t_ea, input int t_w);
    bit r_err, r_done;
    int r_ea, r_w, r_lat, nbad;
    setup(s5, b9, dmode);
    model(e);
    run_session(e, gapmax, -1, r_err, r_done, r_ea, r_w, r_lat);
    chk("error", r_err, m_err);
    chk("err_addr", r_ea, m_err ? m_ea : 0);
    chk("words_written", r_w, m_w);
    chk("done_seen", r_done, !m_err);
    chk("erase_pulses", nerase, e);
    chk("write_count", nwr, m_nwr);
    chk("write_protocol", nviol, 0);
    if (e && m_err && m_nwr == 0) chk("ready_during_echk_fail", nready, 0);
    if (gapmax == 0 && !m_err) chk("done_latency", r_lat, 32);
    @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== m_fin[i]) nbad++;
    chk("array_contents", nbad, 0);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("error_held", error, m_err);
    if (tab) begin
      chk("tab_error", r_err, t_err);
      chk("tab_err_addr", r_ea, t_ea);
      chk("tab_words", r_w, t_w);
    end
  endtask

  typedef struct {
    bit e; bit s5; bit b9; int gap; int dmode;
    bit xerr; int xea; int xw;
  } scen_t;

  initial begin
    scen_t tbl [5];
    bit r_err, r_done;
    int r_ea, r_w, r_lat;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 16};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 16};
    tbl[2] = '{0, 1, 0, 0, 1, 1, 5, 5};
    tbl[3] = '{1, 0, 1, 0, 0, 1, 9, 0};
    tbl[4] = '{0, 0, 0, 3, 0, 0, 0, 16};

    bus.in_valid = 1; bus.in_data = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_outs", outs_vec(), 64'd0);
    bus.in_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("after_release_outs", outs_vec(), 64'd0);

    for (int i = 0; i < 5; i++)
      do_scen(tbl[i].e, tbl[i].s5, tbl[i].b9, tbl[i].gap, tbl[i].dmode,
              1, tbl[i].xerr, tbl[i].xea, tbl[i].xw);

    setup(0, 0, 0);
    run_session(0, 0, 7, r_err, r_done, r_ea, r_w, r_lat);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_reset_idle", outs_vec(), 64'd0);
    do_scen(0, 0, 0, 0, 0, 1, 0, 0, 16);

    for (int k = 0; k < 8; k++)
      do_scen(1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 4) == 0,
              int'($urandom % 4), 2, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
